// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: programmable serial pattern detector with arm/stop sequencing,
// saturating match counter, auto-stop target and a sticky, acknowledged done flag.
module seq_det_ctrl #(
    parameter  int unsigned MAX_LEN = 8,
    parameter  int unsigned CNT_W   = 8,
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               stop,
    input  logic               in,
    input  logic               in_valid,
    input  logic               done_ack,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q,   state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic               overlap_q, overlap_d;
    logic [CNT_W-1:0]   target_q,  target_d;
    // Only MAX_LEN-1 past bits are kept; the incoming bit completes the window.
    logic [MAX_LEN-2:0] hist_q,    hist_d;
    logic [LEN_W-1:0]   seen_q,    seen_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               match_q,   match_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] shift_hist_c;
    logic [MAX_LEN-1:0] len_mask_c;
    logic [LEN_W-1:0]   seen_inc_c;
    logic [CNT_W-1:0]   cnt_inc_c;
    logic               hit_c;
    logic [LEN_W-1:0]   start_len_c;
    logic               start_len_ok_c;

    // Window compare: shifted history against the low len bits of the pattern.
    always_comb begin
        shift_hist_c = {hist_q, in};
        seen_inc_c   = (seen_q >= LEN_W'(MAX_LEN)) ? seen_q : seen_q + LEN_W'(1);
        cnt_inc_c    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        len_mask_c   = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask_c[i] = (LEN_W'(i) < len_q);
        end
        hit_c = (seen_inc_c >= len_q) &&
                ((shift_hist_c & len_mask_c) == (pattern_q & len_mask_c));
    end

    // A config write in the same cycle as start is seen by that start.
    always_comb begin
        start_len_c    = cfg_we ? cfg_len : len_q;
        start_len_ok_c = (start_len_c != '0) && (start_len_c <= LEN_W'(MAX_LEN));
    end

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        target_d  = target_q;
        hist_d    = hist_q;
        seen_d    = seen_q;
        cnt_d     = cnt_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    len_d     = cfg_len;
                    overlap_d = cfg_overlap;
                    target_d  = cfg_target;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    if (start_len_ok_c) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                        hist_d  = '0;
                        seen_d  = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            ST_ARMED: begin
                if (cfg_we) begin
                    cfg_err_d = 1'b1;
                end
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (in_valid) begin
                    hist_d = shift_hist_c[MAX_LEN-2:0];
                    seen_d = seen_inc_c;
                    if (hit_c) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc_c;
                        if (!overlap_q) begin
                            seen_d = '0;
                        end
                        if ((target_q != '0) && (cnt_inc_c == target_q)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                if (cfg_we) begin
                    cfg_err_d = 1'b1;
                end
                if (done_ack) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ARMED);
        done_d = (state_d == ST_DONE);
    end

    // State, config and status registers with synchronous reset to defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pattern_q <= MAX_LEN'(4'b1010);
            len_q     <= LEN_W'(4);
            overlap_q <= 1'b1;
            target_q  <= '0;
            hist_q    <= '0;
            seen_q    <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            target_q  <= target_d;
            hist_q    <= hist_d;
            seen_q    <= seen_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: one task per scenario, inline checks.
module tb_seq_det_ctrl;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic               start;
    logic               stop;
    logic               in_r;
    logic               in_valid;
    logic               done_ack;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               done;
    logic               cfg_err;

    int checks = 0;
    int errors = 0;

    seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
        .start(start), .stop(stop), .in(in_r), .in_valid(in_valid),
        .done_ack(done_ack), .match(match), .match_cnt(match_cnt),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are read 1 ns after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        in_r = b; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                             input logic ov, input logic [CNT_W-1:0] t);
        cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_target = t;
        cfg_we = 1'b1;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        checks++; if (match !== 1'b0)      begin errors++; $display("FAIL reset_match: got %0b exp 0", match); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %0b exp 0", done); end
        checks++; if (cfg_err !== 1'b0)    begin errors++; $display("FAIL reset_cfg_err: got %0b exp 0", cfg_err); end
        checks++; if (match_cnt !== 8'd0)  begin errors++; $display("FAIL reset_cnt: got %0d exp 0", match_cnt); end
    endtask

    // Default 1010 overlapping: 101010 matches after bits 4 and 6.
    task automatic test_overlap();
        logic [5:0] bits;
        logic [5:0] exp_m;
        bits  = 6'b101010;
        exp_m = 6'b000101;
        do_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovl_busy_start: got %0b exp 1", busy); end
        for (int i = 5; i >= 0; i--) begin
            send(bits[i]);
            checks++; if (match !== exp_m[i]) begin errors++; $display("FAIL ovl_match_bit%0d: got %0b exp %0b", 6 - i, match, exp_m[i]); end
        end
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL ovl_cnt: got %0d exp 2", match_cnt); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL ovl_busy: got %0b exp 1", busy); end
        do_stop();
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL stop_busy: got %0b exp 0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL stop_done: got %0b exp 0", done); end
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL stop_cnt_hold: got %0d exp 2", match_cnt); end
    endtask

    // Non-overlapping: matched bits are consumed, single match.
    task automatic test_non_overlap();
        logic [5:0] bits;
        logic [5:0] exp_m;
        bits  = 6'b101010;
        exp_m = 6'b000100;
        cfg_write(8'b0000_1010, 4'd4, 1'b0, 8'd0);
        do_start();
        for (int i = 5; i >= 0; i--) begin
            send(bits[i]);
            checks++; if (match !== exp_m[i]) begin errors++; $display("FAIL novl_match_bit%0d: got %0b exp %0b", 6 - i, match, exp_m[i]); end
        end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL novl_cnt: got %0d exp 1", match_cnt); end
        do_stop();
    endtask

    // 111, target 2: DONE on the second hit, later input ignored, ack returns to IDLE.
    task automatic test_target();
        logic [4:0] exp_m;
        logic [4:0] exp_busy;
        logic [4:0] exp_done;
        exp_m    = 5'b00110;
        exp_busy = 5'b11100;
        exp_done = 5'b00011;
        cfg_write(8'b0000_0111, 4'd3, 1'b1, 8'd2);
        do_start();
        for (int i = 4; i >= 0; i--) begin
            send(1'b1);
            checks++; if (match !== exp_m[i])   begin errors++; $display("FAIL tgt_match_bit%0d: got %0b exp %0b", 5 - i, match, exp_m[i]); end
            checks++; if (busy !== exp_busy[i]) begin errors++; $display("FAIL tgt_busy_bit%0d: got %0b exp %0b", 5 - i, busy, exp_busy[i]); end
            checks++; if (done !== exp_done[i]) begin errors++; $display("FAIL tgt_done_bit%0d: got %0b exp %0b", 5 - i, done, exp_done[i]); end
        end
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL tgt_cnt: got %0d exp 2", match_cnt); end
        do_start();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL tgt_start_no_ack_done: got %0b exp 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tgt_start_no_ack_busy: got %0b exp 0", busy); end
        done_ack = 1'b1;
        cycle();
        done_ack = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL tgt_ack_done: got %0b exp 1->0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tgt_ack_busy: got %0b exp 0", busy); end
    endtask

    // in_valid gaps neither shift, count nor match.
    task automatic test_valid_gap();
        cfg_write(8'b0000_1010, 4'd4, 1'b1, 8'd0);
        do_start();
        send(1'b1);
        send(1'b0);
        for (int i = 0; i < 3; i++) begin
            in_r = (i % 2 == 0);
            cycle();
            checks++; if (match !== 1'b0) begin errors++; $display("FAIL gap_match_idle%0d: got %0b exp 0", i, match); end
        end
        send(1'b1);
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL gap_match_bit3: got %0b exp 0", match); end
        send(1'b0);
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL gap_match_bit4: got %0b exp 1", match); end
        checks++; if (match_cnt !== 8'd1) begin errors++; $display("FAIL gap_cnt: got %0d exp 1", match_cnt); end
        do_stop();
    endtask

    // Config writes outside IDLE and illegal lengths are rejected.
    task automatic test_cfg_err();
        do_start();
        cfg_write(8'b0000_0010, 4'd2, 1'b1, 8'd0);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_armed_we: got %0b exp 1", cfg_err); end
        cycle();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_pulse_len: got %0b exp 0", cfg_err); end
        send(1'b1);
        send(1'b0);
        checks++; if (match !== 1'b0) begin errors++; $display("FAIL err_cfg_unchanged_bit2: got %0b exp 0", match); end
        send(1'b1);
        send(1'b0);
        checks++; if (match !== 1'b1) begin errors++; $display("FAIL err_cfg_unchanged_bit4: got %0b exp 1", match); end
        do_stop();
        cfg_write(8'b0000_1010, 4'd0, 1'b1, 8'd0);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_idle_we: got %0b exp 0", cfg_err); end
        do_start();
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_len0_start: got %0b exp 1", cfg_err); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL err_len0_busy: got %0b exp 0", busy); end
        // Same-cycle write and start: start sees the new legal length.
        cfg_pattern = 8'b0000_1010; cfg_len = 4'd4; cfg_overlap = 1'b1; cfg_target = 8'd0;
        cfg_we = 1'b1; start = 1'b1;
        cycle();
        cfg_we = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL we_start_busy: got %0b exp 1", busy); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL we_start_err: got %0b exp 0", cfg_err); end
    endtask

    // start+stop priority, mid-run reset, default config restored.
    task automatic test_stop_reset();
        logic [5:0] bits;
        logic [5:0] exp_m;
        bits  = 6'b101010;
        exp_m = 6'b000101;
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy: got %0b exp 0", busy); end
        cfg_write(8'b0000_1010, 4'd4, 1'b0, 8'd3);
        do_start();
        send(1'b1); send(1'b0); send(1'b1);
        // The completing bit arrives in the reset cycle and must not match.
        in_r = 1'b0; in_valid = 1'b1; rst = 1'b1;
        cycle();
        in_valid = 1'b0; rst = 1'b0;
        checks++; if (match !== 1'b0)     begin errors++; $display("FAIL rst_mid_match: got %0b exp 0", match); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_mid_busy: got %0b exp 0", busy); end
        checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL rst_mid_cnt: got %0d exp 0", match_cnt); end
        checks++; if (done !== 1'b0 || cfg_err !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got done=%0b err=%0b exp 0,0", done, cfg_err); end
        do_start();
        for (int i = 5; i >= 0; i--) begin
            send(bits[i]);
            checks++; if (match !== exp_m[i]) begin errors++; $display("FAIL rst_default_bit%0d: got %0b exp %0b", 6 - i, match, exp_m[i]); end
        end
        checks++; if (match_cnt !== 8'd2) begin errors++; $display("FAIL rst_default_cnt: got %0d exp 2", match_cnt); end
        do_stop();
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cfg_target = '0; start = 1'b0; stop = 1'b0; in_r = 1'b0; in_valid = 1'b0;
        done_ack = 1'b0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_target();
        test_valid_gap();
        test_cfg_err();
        test_stop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial pattern-detector controller. It generalises the fixed 1010 overlapping detector: software-configured pattern, length and overlap mode, plus arm/stop sequencing, a match counter and a stop-after-N-matches target.
It sits between a serial input source and a status/interrupt consumer. It sequences detection runs and reports completion with a sticky done flag that must be acknowledged.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16).
CNT_W, 8, width of match counter and target register.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous, active-high reset.
cfg_we  input  1  config write strobe; accepted only in IDLE.
cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
cfg_len  input  $clog2(MAX_LEN+1)  pattern length; legal range 1..MAX_LEN.
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
cfg_target  input  CNT_W  matches before auto-stop; 0 = unlimited.
start  input  1  arm request.
stop  input  1  abort request.
in  input  1  serial data bit.
in_valid  input  1  in is sampled only when high.
done_ack  input  1  clears done and returns the block to IDLE.
match  output  1  one-cycle pulse per detected pattern.
match_cnt  output  CNT_W  matches in the current run; saturating.
busy  output  1  high in ARMED.
done  output  1  high in DONE (sticky).
cfg_err  output  1  one-cycle pulse on a rejected config write or start.

Behaviour:
- Reset: state IDLE.
- Reset clears match, busy, done, cfg_err, match_cnt, history register and seen-count.
- Reset loads default config: pattern = 1010 (low 4 bits, rest 0), len = 4, overlap = 1, target = 0.
- Reset asserted mid-run aborts immediately; no match pulse is emitted in the reset cycle.
- States: IDLE, ARMED, DONE.
- IDLE:
  - cfg_we latches all cfg_* fields.
  - start with latched len in 1..MAX_LEN goes to ARMED and clears match_cnt, history and seen-count.
  - start with latched len of 0 or >MAX_LEN stays in IDLE and pulses cfg_err.
  - cfg_we and start in the same cycle: the write lands first and start uses the new values.
- ARMED:
  - On each edge with in_valid = 1: history <= {history[MAX_LEN-2:0], in}; seen-count increments, saturating at MAX_LEN.
  - Hit condition: seen-count (after increment) >= len, and history low len bits (after shift) == pattern low len bits.
  - On a hit, match is high in the following cycle (1-cycle latency) and match_cnt increments, saturating at 2^CNT_W-1.
  - Overlap = 0: on a hit, seen-count resets to 0, so the matched bits cannot be reused.
  - Overlap = 1: history and seen-count are kept after a hit.
  - cfg_we in ARMED is ignored and pulses cfg_err; latched config is unchanged.
  - stop goes to IDLE. match_cnt holds its value; done is not set. A hit in the stop cycle is discarded.
  - A hit that makes match_cnt equal a nonzero target goes to DONE on that edge. The match pulse is still emitted and busy drops in the same cycle match rises.
  - start while ARMED is ignored.
- DONE:
  - done = 1 and in is ignored.
  - done_ack goes to IDLE; done clears the next cycle.
  - start without done_ack is ignored. cfg_we is rejected with cfg_err.
- Simultaneous start and stop: stop wins (IDLE stays IDLE; ARMED goes to IDLE).
- in_valid = 0 cycles do not shift, count or match.
- busy = (state == ARMED); done = (state == DONE); both registered.

Test Plan:
1. Reset defaults, start, stream 1,0,1,0,1,0 (in_valid = 1) -> match pulses 1 cycle after bits 4 and 6; match_cnt = 2; busy stays 1.
2. Write overlap = 0, start, same stream 1,0,1,0,1,0 -> single match after bit 4; match_cnt = 1.
3. Write pattern = 111, len = 3, overlap = 1, target = 2; start; stream 1,1,1,1,1 -> matches after bits 3 and 4; DONE after bit 4; bit 5 ignored; match_cnt = 2; done = 1 until done_ack, then IDLE.
4. Defaults; stream 1,0,1,0 with in_valid dropped for 3 cycles between bits 2 and 3 -> exactly one match after bit 4; no spurious pulses in the gap.
5. In ARMED, pulse cfg_we with len = 2 -> cfg_err 1 cycle; config unchanged (default 1010 still matches). Write len = 0 in IDLE then start -> cfg_err; busy stays 0.
6. Assert start and stop together in ARMED -> IDLE. Assert rst mid-pattern after bits 1,0,1 -> all outputs 0. Default pattern restored; after restart, a fresh 1,0,1,0 is needed to match.
